// File: rtl/luces_pkg.sv
// Shared encodings for the LED sequencer: FSM states, pattern modes, speed width
// and the LED value loaded at reset.
package luces_pkg;
    localparam logic [1:0] KIT_IZQ = 2'd0;
    localparam logic [1:0] KIT_DER = 2'd1;
    localparam logic [1:0] ROT     = 2'd2;
    localparam logic [1:0] BLINK   = 2'd3;

    localparam logic [1:0] MODE_KIT   = 2'b00;
    localparam logic [1:0] MODE_ROT   = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    localparam int              VEL_W   = 2;
    localparam logic [VEL_W-1:0] VEL_MAX = 2'd3;
    localparam logic [7:0]       LED_RST = 8'h01;
endpackage

// File: rtl/detector_pulsador.sv
// Two-flop synchronizer plus falling-edge detector for one active-low push-button.
// A press is only recognised once the button has been seen released after reset.
module detector_pulsador (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic press_o
);
    logic       sync1_q, sync2_q, prev_q, armed_q;
    logic [1:0] vld_q;

    // vld_q marks when sync2_q holds a real sample instead of its reset value
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            vld_q   <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            vld_q   <= {vld_q[0], 1'b1};
            armed_q <= armed_q | (vld_q[1] & sync2_q);
        end
    end

    assign press_o = armed_q & prev_q & ~sync2_q;
endmodule

// File: rtl/secuenciador_kit.sv
// LED pattern sequencer: speed-controlled prescaler producing TICK, and a pattern
// FSM (KIT bounce, rotate, blink, hold) that advances only on TICK.
module secuenciador_kit
    import luces_pkg::*;
#(
    parameter int unsigned DIV_BASE = 5_000_000
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             ENABLE,
    input  logic             KEY_UP,
    input  logic             KEY_DOWN,
    input  logic [1:0]       SW_MODE,
    output logic [7:0]       LED,
    output logic [VEL_W-1:0] VEL,
    output logic             TICK
);
    localparam int CNT_W = $clog2(DIV_BASE * 8);

    logic             up_press, dn_press, tick;
    logic [VEL_W-1:0] vel_q, vel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, last_cnt;
    logic [1:0]       state_q, state_d;
    logic [7:0]       led_q, led_d;

    detector_pulsador u_det_up (
        .clk_i  (CLK),
        .rst_ni (RSTn),
        .key_i  (KEY_UP),
        .press_o(up_press)
    );

    detector_pulsador u_det_dn (
        .clk_i  (CLK),
        .rst_ni (RSTn),
        .key_i  (KEY_DOWN),
        .press_o(dn_press)
    );

    always_comb begin
        vel_d = vel_q;
        if (up_press && !dn_press && vel_q != VEL_MAX)
            vel_d = vel_q + 1'b1;
        else if (dn_press && !up_press && vel_q != '0)
            vel_d = vel_q - 1'b1;
    end

    assign last_cnt = CNT_W'((DIV_BASE << (VEL_MAX - vel_q)) - 1);
    assign tick     = ENABLE && (cnt_q == last_cnt);

    // an effective speed change restarts the period; saturated presses do not
    always_comb begin
        cnt_d = cnt_q;
        if (vel_d != vel_q)
            cnt_d = '0;
        else if (tick)
            cnt_d = '0;
        else if (ENABLE)
            cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        if (tick) begin
            case (SW_MODE)
                MODE_KIT: begin
                    case (state_q)
                        KIT_IZQ: begin
                            led_d = {led_q[6:0], 1'b0};
                            if (led_d == 8'h80) state_d = KIT_DER;
                        end
                        KIT_DER: begin
                            led_d = {1'b0, led_q[7:1]};
                            if (led_d == 8'h01) state_d = KIT_IZQ;
                        end
                        default: begin
                            led_d   = LED_RST;
                            state_d = KIT_IZQ;
                        end
                    endcase
                end
                MODE_ROT: begin
                    state_d = ROT;
                    led_d   = (state_q == BLINK) ? LED_RST : {led_q[6:0], led_q[7]};
                end
                MODE_BLINK: begin
                    state_d = BLINK;
                    led_d   = (state_q == BLINK) ? ~led_q : 8'hFF;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            vel_q   <= '0;
            cnt_q   <= '0;
            state_q <= KIT_IZQ;
            led_q   <= LED_RST;
        end else begin
            vel_q   <= vel_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            led_q   <= led_d;
        end
    end

    assign LED  = led_q;
    assign VEL  = vel_q;
    assign TICK = tick;
endmodule

// File: tb/tb_secuenciador_kit.sv
// Self-checking bench for secuenciador_kit with DIV_BASE=4 (periods 32/16/8/4).
module tb_secuenciador_kit;
    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       ENABLE = 1'b1;
    logic       KEY_UP = 1'b1;
    logic       KEY_DOWN = 1'b1;
    logic [1:0] SW_MODE = 2'b00;
    logic [7:0] LED;
    logic [1:0] VEL;
    logic       TICK;

    always #5 CLK = ~CLK;

    secuenciador_kit #(.DIV_BASE(4)) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .ENABLE  (ENABLE),
        .KEY_UP  (KEY_UP),
        .KEY_DOWN(KEY_DOWN),
        .SW_MODE (SW_MODE),
        .LED     (LED),
        .VEL     (VEL),
        .TICK    (TICK)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] led;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;

    task automatic step(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // returns the number of clocks until TICK is seen high at a sample point
    task automatic wait_tick(input int max, output int n);
        n = 0;
        while (TICK !== 1'b1 && n <= max) begin
            step();
            n++;
        end
        if (n > max) chk("tick_timeout", n, max);
    endtask

    task automatic press(input logic up, input logic dn);
        KEY_UP   = ~up;
        KEY_DOWN = ~dn;
        step(3);
        KEY_UP   = 1'b1;
        KEY_DOWN = 1'b1;
    endtask

    task automatic add(input logic [1:0] m, input logic [7:0] l);
        vec_t v;
        v.mode = m;
        v.led  = l;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         w, nticks, nbad;
        logic [7:0] held, e;

        for (int k = 1; k < 8; k++) add(2'b00, 8'(1 << k));
        for (int k = 6; k >= 0; k--) add(2'b00, 8'(1 << k));
        add(2'b00, 8'h02);
        add(2'b10, 8'hFF); add(2'b10, 8'h00); add(2'b10, 8'hFF);
        for (int k = 0; k < 8; k++) add(2'b01, 8'(1 << k));
        add(2'b01, 8'h01);
        add(2'b11, 8'h01); add(2'b11, 8'h01);
        add(2'b00, 8'h01); add(2'b00, 8'h02);

        step(2);
        chk("rst_led", LED, 8'h01);
        chk("rst_vel", VEL, 0);
        chk("rst_tick", TICK, 0);
        RSTn = 1'b1;

        foreach (vecs[i]) begin
            SW_MODE = vecs[i].mode;
            exp_q.push_back(vecs[i].led);
            wait_tick(40, w);
            chk($sformatf("period32[%0d]", i), w, 31);
            step();
            e = exp_q.pop_front();
            chk($sformatf("led[%0d]", i), LED, e);
        end

        // speed up through every level, then a saturated press
        press(1, 0); chk("vel_up1", VEL, 1);
        wait_tick(40, w); chk("restart16", w, 15);
        step(); wait_tick(40, w); chk("period16", w, 15);
        press(1, 0); chk("vel_up2", VEL, 2);
        wait_tick(40, w); chk("restart8", w, 7);
        step(); wait_tick(40, w); chk("period8", w, 7);
        press(1, 0); chk("vel_up3", VEL, 3);
        wait_tick(40, w); chk("restart4", w, 3);
        step(); wait_tick(40, w); chk("period4", w, 3);
        press(1, 0); chk("vel_sat3", VEL, 3);
        wait_tick(40, w); chk("sat_no_clear", w, 1);

        press(0, 1); chk("vel_dn2", VEL, 2);
        wait_tick(40, w); chk("restart8b", w, 7);
        step();
        press(1, 1); chk("vel_both", VEL, 2);
        wait_tick(40, w); chk("both_no_clear", w, 4);

        step(3);
        press(0, 1); chk("vel_dn1", VEL, 1); step(3);
        press(0, 1); chk("vel_dn0", VEL, 0); step(3);
        press(0, 1); chk("vel_sat0", VEL, 0); step(3);

        // freeze mid-period and resume from the held count
        wait_tick(40, w);
        step(11);
        ENABLE = 1'b0;
        held   = LED;
        nticks = 0;
        nbad   = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (TICK !== 1'b0) nticks++;
            if (LED !== held) nbad++;
        end
        chk("dis_tick", nticks, 0);
        chk("dis_led", nbad, 0);
        ENABLE = 1'b1;
        wait_tick(40, w); chk("resume", w, 21);

        ENABLE = 1'b0;
        press(1, 0); chk("dis_vel_up", VEL, 1); step(3);
        press(0, 1); chk("dis_vel_dn", VEL, 0); step(3);
        ENABLE = 1'b1;

        // reset mid KIT bounce with a held key
        RSTn = 1'b0; step(); RSTn = 1'b1;
        SW_MODE = 2'b00;
        for (int t = 0; t < 9; t++) begin
            wait_tick(40, w);
            step();
        end
        chk("kit_der20", LED, 8'h20);
        press(1, 0); chk("pre_rst_vel", VEL, 1);
        step(3);
        KEY_UP = 1'b0;
        RSTn   = 1'b0;
        step();
        chk("mid_rst_led", LED, 8'h01);
        chk("mid_rst_vel", VEL, 0);
        chk("mid_rst_tick", TICK, 0);
        RSTn = 1'b1;
        step(10);
        chk("held_key_nopress", VEL, 0);
        KEY_UP = 1'b1;
        step(5);
        chk("release_nopress", VEL, 0);
        press(1, 0); chk("post_rst_press", VEL, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
